// File: rtl/or_gate_pkg.sv
// or_gate_pkg: shared constants and the pipeline stage payload type for
// or_gate_core and its register stage.
//   OR_GATE_DEFAULT_WIDTH : default operand width
//   OR_GATE_MAX_WIDTH     : widest legal operand; the payload is sized to it
//   OR_GATE_MAX_STAGES    : deepest legal registered path
//   or_stage_t            : {data, valid} carried between stages
package or_gate_pkg;

  localparam int OR_GATE_DEFAULT_WIDTH = 1;
  localparam int OR_GATE_MAX_WIDTH     = 64;
  localparam int OR_GATE_MAX_STAGES    = 8;

  // Data is sized for the widest legal operand so one type serves every
  // WIDTH; narrower instances keep the upper bits at zero.
  typedef struct packed {
    logic [OR_GATE_MAX_WIDTH-1:0] data;
    logic                         valid;
  } or_stage_t;

endpackage

// File: rtl/or_gate_stage.sv
// or_gate_stage: one valid-qualified register stage of the y_q path.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, clears data and valid
//   i_stage : incoming {data, valid}
//   o_stage : registered {data, valid}
// The payload is loaded only when the incoming valid is set; a bubble
// clears valid but leaves the stored data untouched.
module or_gate_stage
  import or_gate_pkg::*;
#(
  parameter int WIDTH = OR_GATE_DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  input  or_stage_t i_stage,
  output or_stage_t o_stage
);

  // Keeps bits above WIDTH at zero regardless of what arrives there.
  localparam logic [OR_GATE_MAX_WIDTH-1:0] DATA_MASK =
    {OR_GATE_MAX_WIDTH{1'b1}} >> (OR_GATE_MAX_WIDTH - WIDTH);

  or_stage_t r_stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage.valid <= i_stage.valid;
      if (i_stage.valid) begin
        r_stage.data <= i_stage.data & DATA_MASK;
      end
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/or_gate_core.sv
// or_gate_core: bitwise two-input OR with a combinational output and an
// optional valid-qualified pipelined copy.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (registered path only)
//   a, b      : WIDTH-bit operands
//   in_valid  : qualifies a/b for the registered path
//   y         : combinational a | b
//   y_q       : a | b delayed by STAGES cycles (combinational when STAGES=0)
//   out_valid : qualifies y_q
module or_gate_core
  import or_gate_pkg::*;
#(
  parameter int WIDTH  = OR_GATE_DEFAULT_WIDTH,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > OR_GATE_MAX_WIDTH) begin : g_bad_width
    $error("or_gate_core: WIDTH out of range 1..64");
  end
  if (STAGES < 0 || STAGES > OR_GATE_MAX_STAGES) begin : g_bad_stages
    $error("or_gate_core: STAGES out of range 0..8");
  end

  logic [WIDTH-1:0] w_or;

  // X on an operand is deliberately allowed to reach y.
  assign w_or = a | b;
  assign y    = w_or;

  if (STAGES == 0) begin : g_bypass
    assign y_q       = w_or;
    assign out_valid = in_valid;

    // clk and rst have no role when the registered path is bypassed.
    logic w_clk_rst_unused;
    assign w_clk_rst_unused = clk & rst;
  end else begin : g_pipe
    // w_chain[k] feeds stage k; w_chain[STAGES] is the pipeline output.
    or_stage_t w_chain [STAGES+1];

    assign w_chain[0] = {OR_GATE_MAX_WIDTH'(w_or), in_valid};

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      or_gate_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_stage (w_chain[gi]),
        .o_stage (w_chain[gi+1])
      );
    end

    assign out_valid = w_chain[STAGES].valid;

    // Upper payload bits are always zero; only the low WIDTH bits leave.
    if (WIDTH < OR_GATE_MAX_WIDTH) begin : g_narrow
      logic [OR_GATE_MAX_WIDTH-WIDTH-1:0] w_tail_unused;
      assign {w_tail_unused, y_q} = w_chain[STAGES].data;
    end else begin : g_full
      assign y_q = w_chain[STAGES].data;
    end
  end

endmodule

// File: tb/tb_or_gate_core.sv
module tb_or_gate_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] a, b;
  logic       iv;

  logic       y1, yq1, ov1;
  logic [3:0] y3, yq3;
  logic       ov3;
  logic [3:0] y2, yq2;
  logic       ov2;
  logic [3:0] y0, yq0;
  logic       ov0;

  or_gate_core #(.WIDTH(1), .STAGES(1)) u_w1s1 (
    .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .in_valid(iv),
    .y(y1), .y_q(yq1), .out_valid(ov1));
  or_gate_core #(.WIDTH(4), .STAGES(3)) u_w4s3 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(iv),
    .y(y3), .y_q(yq3), .out_valid(ov3));
  or_gate_core #(.WIDTH(4), .STAGES(2)) u_w4s2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(iv),
    .y(y2), .y_q(yq2), .out_valid(ov2));
  or_gate_core #(.WIDTH(4), .STAGES(0)) u_w4s0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(iv),
    .y(y0), .y_q(yq0), .out_valid(ov0));

  // Scoreboard entry: one valid sample expected on pipe `pipe` right after
  // edge number `due`.
  typedef struct {
    int         pipe;
    int         due;
    logic [3:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       y1;
    logic [3:0] y4;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[6];
  logic [3:0] held[3];
  bit         live = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Pipe index -> stage count: 0 is u_w1s1, 1 is u_w4s3, 2 is u_w4s2.
  function automatic int stages_of(input int p);
    return (p == 0) ? 1 : ((p == 1) ? 3 : 2);
  endfunction

  function automatic logic [3:0] yq_of(input int p);
    case (p)
      0:       return {3'b000, yq1};
      1:       return yq3;
      default: return yq2;
    endcase
  endfunction

  function automatic logic ov_of(input int p);
    case (p)
      0:       return ov1;
      1:       return ov3;
      default: return ov2;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Combinational outputs: y on every instance, and the bypass y_q/out_valid.
  task automatic check_comb();
    cmp("y_w1", {3'b000, y1}, {3'b000, a[0] | b[0]});
    cmp("y_w4s3", y3, a | b);
    cmp("y_w4s2", y2, a | b);
    cmp("bypass_y", y0, a | b);
    cmp("bypass_yq", yq0, a | b);
    cmp("bypass_valid", {3'b000, ov0}, {3'b000, iv});
  endtask

  task automatic model_edge();
    cyc++;
    if (rst) begin
      sb.delete();
      for (int p = 0; p < 3; p++) held[p] = 4'b0000;
      live = 1'b1;
    end else if (iv && live) begin
      for (int p = 0; p < 3; p++) begin
        exp_t e;
        e.pipe = p;
        e.due  = cyc + stages_of(p) - 1;
        e.data = (p == 0) ? {3'b000, a[0] | b[0]} : (a | b);
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_pipes();
    if (!live) return;
    for (int p = 0; p < 3; p++) begin
      int         idx;
      logic       expv;
      logic [3:0] expd;
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].pipe == p) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0 && sb[idx].due == cyc) begin
        expv    = 1'b1;
        expd    = sb[idx].data;
        held[p] = expd;
        sb.delete(idx);
      end else begin
        expv = 1'b0;
        expd = held[p];
      end
      cmp($sformatf("s%0d_out_valid", stages_of(p)), {3'b000, ov_of(p)}, {3'b000, expv});
      cmp($sformatf("s%0d_y_q", stages_of(p)), yq_of(p), expd);
    end
  endtask

  task automatic drive(input logic [3:0] na, input logic [3:0] nb,
                       input logic nv, input logic nr);
    a   = na;
    b   = nb;
    iv  = nv;
    rst = nr;
    #1;
    check_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    $display("edge %0d rst=%b a=%b b=%b iv=%b | s1 %b/%b s3 %b/%b s2 %b/%b s0 %b/%b",
             cyc, rst, a, b, iv, ov1, yq1, ov3, yq3, ov2, yq2, ov0, yq0);
    check_pipes();
    check_comb();
  endtask

  initial begin
    vecs[0] = '{a: 4'b0000, b: 4'b0000, y1: 1'b0, y4: 4'b0000};
    vecs[1] = '{a: 4'b0000, b: 4'b0001, y1: 1'b1, y4: 4'b0001};
    vecs[2] = '{a: 4'b0001, b: 4'b0000, y1: 1'b1, y4: 4'b0001};
    vecs[3] = '{a: 4'b0001, b: 4'b0001, y1: 1'b1, y4: 4'b0001};
    vecs[4] = '{a: 4'b1010, b: 4'b0101, y1: 1'b1, y4: 4'b1111};
    vecs[5] = '{a: 4'b1000, b: 4'b0000, y1: 1'b0, y4: 4'b1000};

    rst = 1'b0;
    iv  = 1'b0;
    a   = 4'b0000;
    b   = 4'b0000;

    // Truth table and vector OR on y, no clock involvement.
    for (int i = 0; i < 6; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      #10;
      cmp("table_y_w1", {3'b000, y1}, {3'b000, vecs[i].y1});
      cmp("table_y_w4", y3, vecs[i].y4);
      cmp("table_bypass_yq", yq0, vecs[i].y4);
    end

    // Reset held two edges with in_valid high: must be ignored.
    @(negedge clk);
    drive(4'b1111, 4'b0000, 1'b1, 1'b1);
    tick();
    drive(4'b0110, 4'b0001, 1'b1, 1'b1);
    tick();

    // Single-sample latency, then hold behaviour on the following edge.
    drive(4'b0001, 4'b0000, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back vector stream from the table.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      cmp("stream_y", y3, vecs[i].y4);
      tick();
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // Reset in the middle of a valid stream, coincident with in_valid=1.
    for (int i = 0; i < 6; i++) begin
      drive(4'($urandom), 4'($urandom), 1'b1, (i == 2));
      tick();
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // Bubbles: alternating valid while operands change every cycle.
    for (int i = 0; i < 12; i++) begin
      drive(4'($urandom), 4'($urandom), (i % 2 == 0), 1'b0);
      tick();
    end
    drive(4'($urandom), 4'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // Random traffic with occasional reset.
    for (int i = 0; i < 100; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      tick();
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
